// File: rtl/hifigan_conv_sequencer.sv
// Walks one 1-D conv layer through the MAC array: issues activation/weight tap reads,
// aligns MAC calc/clear to the returning data and hands each finished accumulator downstream.
module hifigan_conv_sequencer #(
  parameter int unsigned CH_W   = 10,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CH_W-1:0]   i_num_in_ch,
  input  logic [CH_W-1:0]   i_num_out_ch,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_act_addr,
  output logic [ADDR_W-1:0] o_wgt_addr,
  output logic              o_mac_calc_en,
  output logic              o_mac_clear_acc,
  input  logic [31:0]       i_mac_acc_raw,
  input  logic              i_mac_valid,
  output logic              o_res_valid,
  output logic [31:0]       o_res_data,
  output logic [CH_W-1:0]   o_res_ch,
  input  logic              i_res_ready
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHold} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   n_in_q, n_in_d;
  logic [CH_W-1:0]   n_out_q, n_out_d;
  logic [CH_W-1:0]   in_ch_q, in_ch_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              calc_en_q, calc_en_d;
  logic              clear_q, clear_d;
  logic              last1_q, last1_d;
  logic              last2_q, last2_d;
  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic              done_q, done_d;
  logic              rd_en;

  // Capture timing is fixed by the tag pipeline; MAC valid is only a cross-check for the bench.
  logic unused_mac_valid;
  assign unused_mac_valid = i_mac_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      n_in_q      <= '0;
      n_out_q     <= '0;
      in_ch_q     <= '0;
      out_ch_q    <= '0;
      base_q      <= '0;
      calc_en_q   <= 1'b0;
      clear_q     <= 1'b0;
      last1_q     <= 1'b0;
      last2_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_in_q      <= n_in_d;
      n_out_q     <= n_out_d;
      in_ch_q     <= in_ch_d;
      out_ch_q    <= out_ch_d;
      base_q      <= base_d;
      calc_en_q   <= calc_en_d;
      clear_q     <= clear_d;
      last1_q     <= last1_d;
      last2_q     <= last2_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_in_d      = n_in_q;
    n_out_d     = n_out_q;
    in_ch_d     = in_ch_q;
    out_ch_d    = out_ch_q;
    base_d      = base_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    calc_en_d   = 1'b0;
    clear_d     = 1'b0;
    last1_d     = 1'b0;
    last2_d     = last1_q;
    done_d      = 1'b0;
    rd_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          n_in_d   = (i_num_in_ch == '0) ? CH_W'(1) : i_num_in_ch;
          n_out_d  = (i_num_out_ch == '0) ? CH_W'(1) : i_num_out_ch;
          out_ch_d = '0;
          in_ch_d  = '0;
          base_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        rd_en     = 1'b1;
        calc_en_d = 1'b1;
        clear_d   = (in_ch_q == '0);
        if (in_ch_q == n_in_q - CH_W'(1)) begin
          last1_d = 1'b1;
          in_ch_d = '0;
          state_d = StDrain;
        end else begin
          in_ch_d = in_ch_q + CH_W'(1);
        end
      end
      StDrain: begin
        // Final MAC sum is on i_mac_acc_raw exactly when the twice-delayed last tag is high.
        if (last2_q) begin
          res_data_d  = i_mac_acc_raw;
          res_ch_d    = out_ch_q;
          res_valid_d = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (i_res_ready && res_valid_q) begin
          res_valid_d = 1'b0;
          if (out_ch_q == n_out_q - CH_W'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            out_ch_d = out_ch_q + CH_W'(1);
            base_d   = base_q + ADDR_W'(n_in_q);
            in_ch_d  = '0;
            state_d  = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_rd_en         = rd_en;
    o_act_addr      = rd_en ? ADDR_W'(in_ch_q) : '0;
    o_wgt_addr      = rd_en ? (base_q + ADDR_W'(in_ch_q)) : '0;
    o_busy          = (state_q != StIdle);
    o_done          = done_q;
    o_mac_calc_en   = calc_en_q;
    o_mac_clear_acc = clear_q;
    o_res_valid     = res_valid_q;
    o_res_data      = res_data_q;
    o_res_ch        = res_ch_q;
  end

endmodule
